// File: rtl/mem_map_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM states,
// the address-fold constants and the default error fill pattern.
package mem_map_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    localparam logic [15:0] MAP_THRESHOLD     = 16'h0100;
    localparam logic [15:0] MAP_OFFSET        = 16'h0101;
    localparam logic [15:0] FILL_DATA_DEFAULT = 16'hF345;

    // Addresses above the threshold are folded upward (wrapping at 2^16).
    function automatic logic [15:0] map_addr(input logic [15:0] addr);
        logic [15:0] mapped;
        if (addr > MAP_THRESHOLD) begin
            mapped = addr + MAP_OFFSET;
        end else begin
            mapped = addr;
        end
        return mapped;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin decision: on a tie the requester that was not
// granted last wins; a lone requester always wins.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant,
    output logic grant_id
);

    // Combinational grant decision
    always_comb begin
        grant    = req0 | req1;
        grant_id = 1'b0;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = 1'b1;
        end else begin
            grant_id = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU and a DMA requester onto one synchronous RAM port,
// folding high addresses and answering illegal ones with an error response.
module mem_arbiter
    import mem_map_pkg::*;
#(
    parameter logic [15:0] ADDR_LIMIT = 16'h0100,
    parameter logic [15:0] FILL_DATA  = FILL_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [15:0] rdata,
    output logic [8:0]  mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    arb_state_e  state_r, state_nx_s;

    logic        grant_s;
    logic        grant_id_s;
    logic        last_grant_r, last_grant_nx_s;
    logic        owner_r, owner_nx_s;
    logic        we_r, we_nx_s;
    logic        illegal_r, illegal_nx_s;

    logic        sel_we_s;
    logic [15:0] sel_mapped_s;
    logic [15:0] sel_wdata_s;
    logic        sel_illegal_s;

    logic        ack0_r, ack0_nx_s;
    logic        ack1_r, ack1_nx_s;
    logic        err0_r, err0_nx_s;
    logic        err1_r, err1_nx_s;
    logic [15:0] rdata_r, rdata_nx_s;
    logic [8:0]  mem_addr_r, mem_addr_nx_s;
    logic        mem_we_r, mem_we_nx_s;
    logic [15:0] mem_wdata_r, mem_wdata_nx_s;
    logic        busy_r;

    rr_arbiter2 u_rr (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .grant_id   (grant_id_s)
    );

    // Mux the winning requester's command and classify its address
    always_comb begin
        sel_we_s     = 1'b0;
        sel_mapped_s = 16'h0000;
        sel_wdata_s  = 16'h0000;
        if (grant_id_s) begin
            sel_we_s     = we1;
            sel_mapped_s = map_addr(addr1);
            sel_wdata_s  = wdata1;
        end else begin
            sel_we_s     = we0;
            sel_mapped_s = map_addr(addr0);
            sel_wdata_s  = wdata0;
        end
        sel_illegal_s = (sel_mapped_s > ADDR_LIMIT);
    end

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        state_nx_s      = state_r;
        last_grant_nx_s = last_grant_r;
        owner_nx_s      = owner_r;
        we_nx_s         = we_r;
        illegal_nx_s    = illegal_r;
        ack0_nx_s       = 1'b0;
        ack1_nx_s       = 1'b0;
        err0_nx_s       = 1'b0;
        err1_nx_s       = 1'b0;
        rdata_nx_s      = 16'h0000;
        mem_addr_nx_s   = mem_addr_r;
        mem_we_nx_s     = 1'b0;
        mem_wdata_nx_s  = mem_wdata_r;

        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nx_s     = ST_ISSUE;
                    owner_nx_s     = grant_id_s;
                    we_nx_s        = sel_we_s;
                    illegal_nx_s   = sel_illegal_s;
                    mem_addr_nx_s  = sel_mapped_s[8:0];
                    mem_we_nx_s    = sel_we_s & ~sel_illegal_s;
                    mem_wdata_nx_s = sel_wdata_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nx_s = ST_WAIT;
            end
            ST_WAIT: begin
                // RAM data for the ISSUE address is valid now; capture it at this edge
                state_nx_s = ST_DONE;
                ack0_nx_s  = ~owner_r;
                ack1_nx_s  = owner_r;
                err0_nx_s  = ~owner_r & illegal_r;
                err1_nx_s  = owner_r & illegal_r;
                if (illegal_r) begin
                    rdata_nx_s = FILL_DATA;
                end else if (we_r) begin
                    rdata_nx_s = 16'h0000;
                end else begin
                    rdata_nx_s = mem_rdata;
                end
            end
            ST_DONE: begin
                state_nx_s      = ST_IDLE;
                last_grant_nx_s = owner_r;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            we_r         <= 1'b0;
            illegal_r    <= 1'b0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            err0_r       <= 1'b0;
            err1_r       <= 1'b0;
            rdata_r      <= 16'h0000;
            mem_addr_r   <= 9'h000;
            mem_we_r     <= 1'b0;
            mem_wdata_r  <= 16'h0000;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            last_grant_r <= last_grant_nx_s;
            owner_r      <= owner_nx_s;
            we_r         <= we_nx_s;
            illegal_r    <= illegal_nx_s;
            ack0_r       <= ack0_nx_s;
            ack1_r       <= ack1_nx_s;
            err0_r       <= err0_nx_s;
            err1_r       <= err1_nx_s;
            rdata_r      <= rdata_nx_s;
            mem_addr_r   <= mem_addr_nx_s;
            mem_we_r     <= mem_we_nx_s;
            mem_wdata_r  <= mem_wdata_nx_s;
            busy_r       <= (state_nx_s != ST_IDLE);
        end
    end

    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign err0      = err0_r;
    assign err1      = err1_r;
    assign rdata     = rdata_r;
    assign mem_addr  = mem_addr_r;
    assign mem_we    = mem_we_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;
    assign owner     = owner_r;

endmodule
